nn_mac_seq: RTL and testbench
=============================

# nn_mac_seq

Parametrised sequential neuron multiply-accumulate unit for the neuro datapath. It latches a vector of N signed fixed-point inputs and N weights on a start request and streams one lane per cycle through a pipelined multiplier. It accumulates the products at full precision, then rescales and range-limits the dot product into one W-bit neuron pre-activation value. It sits between the weight/input vector registers and the activation stage, and replaces the earlier fixed 8-lane, 17-bit, free-running multiplier loop with a start/done handshake and stall support.

## Interface
- N, default 8: number of lanes (input/weight pairs) per dot product, ≥ 2.
- W, default 17: data width of each x, w lane and of `total`, signed two's complement.
- FRAC, default 0: fractional bits; the accumulated sum is arithmetic-shifted right by FRAC before output.
- MUL_LAT, default 3: multiplier pipeline depth in cycles, ≥ 1.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- ce  input  1  clock enable; low freezes all state, including the multiplier pipeline.
- start  input  1  request a dot product; accepted only when `ce` is high and `busy` is low.
- x  input  N*W  input vector; lane i is x[W*(i+1)-1 : W*i].
- w  input  N*W  weight vector, packed the same way as `x`.
- busy  output  1  high while a dot product is in flight (ISSUE or DRAIN).
- done  output  1  one-cycle pulse when `total` has been updated.
- total  output  W  result; holds its value until the next `done`.
- sat  output  1  saturation flag for the last result; valid with `done` and held with `total`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: accepted `start` latches all lanes of x and w into internal registers, clears the accumulator, and moves to ISSUE.
  - x and w are don't-care after the accepting edge.
- ISSUE: lasts N enabled cycles. Lane index 0..N-1 feeds the latched x[i], w[i] to the multiplier, one lane per cycle. After lane N-1 the block moves to DRAIN.
- DRAIN: lasts MUL_LAT enabled cycles while the last products emerge.
  - Each valid product (full 2W-bit signed) adds into an accumulator of ACC_W = 2W + clog2(N) bits, sign-extended.
  - A valid tag travels alongside the multiplier pipeline. Only tagged products are accumulated.
- DONE: lasts one cycle.
  - `total` is loaded with the range-limited value of (acc >>> FRAC).
  - `done` is asserted and `busy` is low.
  - A `start` in this cycle is accepted (back-to-back operation). Otherwise the block returns to IDLE.
- `start` while `busy` is high is ignored and has no side effects.
- ce low: state, lane index, pipeline, accumulator and outputs all hold. If `done` is high it stays high until the next enabled edge.

## Timing
- Accepted start at edge k: `busy` is high after edge k. `done` is high and `total` is valid after edge k+N+MUL_LAT+1, assuming ce stays high. Latency is N+MUL_LAT+1 cycles.
- Each ce-low cycle during an operation delays `done` by exactly one cycle and does not change the result.
- Minimum start-to-start period is N+MUL_LAT+1 cycles.
- Reset values: total=0, sat=0, done=0, busy=0, state=IDLE, accumulator and pipeline valid tags cleared.
- Reset asserted mid-operation aborts the operation immediately. No `done` is produced for it, and the first `start` after release begins a clean operation.

## Configuration
- NN_MAC_SAT_EN defined:
  - the shifted sum is clipped to [-2^(W-1), 2^(W-1)-1];
  - `sat` is set when clipping occurred.
- NN_MAC_SAT_EN undefined:
  - `total` is the low W bits of the shifted sum (wrap-around);
  - `sat` is tied to 0.

## Structure
- Shared package nn_pkg holds:
  - the state enum (IDLE/ISSUE/DRAIN/DONE);
  - the ACC_W helper function;
  - lane pack/unpack width constants.
- Sub-module nn_mul_pipe: a W×W signed multiplier with a MUL_LAT-deep pipeline, a `ce` gate, a valid tag, and async-reset-cleared tags.

## Test plan
All scenarios use N=8, W=17, FRAC=0, MUL_LAT=3 unless stated otherwise.
- Ramp: x lanes all 1, w lane i = i, start once -> total=28 (0x0001C), sat=0; `done` high exactly 12 cycles after the accepting edge; `busy` high for 11 cycles.
- Sign: x0=-3, w0=5, other lanes 0 -> total=-15 (0x1FFF1).
- Overflow: all lanes x=w=0x0FFFF.
  - NN_MAC_SAT_EN defined -> total=0x0FFFF, sat=1.
  - NN_MAC_SAT_EN undefined -> total=0x00008, sat=0.
- Stall: ramp stimulus with ce low for 5 cycles during DRAIN -> `done` 17 cycles after start, total=28; a start pulsed while busy is ignored.
- Back-to-back: second start (x=2, w=i) asserted in the DONE cycle -> second `done` 12 cycles later with total=56; first total=28 held in between.
- Reset mid-op: rst pulsed 4 cycles into ISSUE -> busy=0, done=0, total=0 immediately; next ramp start -> total=28 with normal latency.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neuro MAC datapath: FSM state encoding,
// accumulator sizing and lane packing constants.
package nn_pkg;

    // Default geometry of the neuron MAC
    localparam int unsigned DEF_N       = 8;
    localparam int unsigned DEF_W       = 17;
    localparam int unsigned DEF_FRAC    = 0;
    localparam int unsigned DEF_MUL_LAT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of a packed vector of n lanes, w bits each
    function automatic int unsigned vec_w(input int unsigned n, input int unsigned w);
        return n * w;
    endfunction

    // Full-precision width of one signed w x w product
    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

    // Accumulator width: full product plus growth for n additions
    function automatic int unsigned acc_w(input int unsigned w, input int unsigned n);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/nn_mul_pipe.sv
// Signed W x W multiplier with a MUL_LAT-deep pipeline and a valid tag
// travelling alongside the data. ce low freezes every stage.
// Ports:
//   clk, rst        clock, async active-high reset (clears tags and data)
//   ce              stage enable
//   in_valid        tag for the operands presented this cycle
//   a, b            signed operands
//   prod            full 2W-bit signed product, MUL_LAT enabled cycles later
//   out_valid       tag aligned with prod
module nn_mul_pipe
    import nn_pkg::*;
#(
    parameter int unsigned W       = DEF_W,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic signed [W-1:0]         a,
    input  logic signed [W-1:0]         b,
    output logic signed [2*W-1:0]       prod,
    output logic                        out_valid
);

    localparam int unsigned PW = prod_w(W);

    logic signed [PW-1:0] pipe [MUL_LAT];
    logic [MUL_LAT-1:0]   vld;

    // Stage 0 multiplies, later stages only delay data and tag together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                pipe[i] <= '0;
            end
        end else if (ce) begin
            pipe[0] <= PW'(a) * PW'(b);
            vld[0]  <= in_valid;
            for (int i = 1; i < int'(MUL_LAT); i++) begin
                pipe[i] <= pipe[i-1];
                vld[i]  <= vld[i-1];
            end
        end
    end

    assign prod      = pipe[MUL_LAT-1];
    assign out_valid = vld[MUL_LAT-1];

endmodule

// File: rtl/nn_mac_seq.sv
// Sequential neuron multiply-accumulate: latches N input/weight lanes on
// start, streams one lane per cycle through nn_mul_pipe, accumulates at full
// precision, then shifts right by FRAC and range-limits to W bits.
// Build option NN_MAC_SAT_EN: clip to the signed W-bit range and flag sat;
// without it the result wraps and sat is 0.
// Ports:
//   clk, rst   clock, async active-high reset
//   ce         clock enable, low freezes all state
//   start      request a dot product (taken in IDLE or DONE)
//   x, w       packed input / weight vectors, lane i at [W*(i+1)-1 : W*i]
//   busy       operation in flight (ISSUE or DRAIN)
//   done       one-cycle pulse when total/sat update
//   total      pre-activation result, held until next done
//   sat        clipping flag for total
// done/total/sat register on the edge that leaves the DONE state, so the
// pulse is visible N+MUL_LAT+1 cycles after the accepting edge.
module nn_mac_seq
    import nn_pkg::*;
#(
    parameter int unsigned N       = DEF_N,
    parameter int unsigned W       = DEF_W,
    parameter int unsigned FRAC    = DEF_FRAC,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               start,
    input  logic [N*W-1:0]     x,
    input  logic [N*W-1:0]     w,
    output logic               busy,
    output logic               done,
    output logic [W-1:0]       total,
    output logic               sat
);

    localparam int unsigned VW      = vec_w(N, W);
    localparam int unsigned PW      = prod_w(W);
    localparam int unsigned ACC_W   = acc_w(W, N);
    localparam int unsigned CNT_MAX = (N > MUL_LAT) ? N : MUL_LAT;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic                    accept_c, fin_c, busy_n;
    logic [VW-1:0]           x_lat, w_lat;
    logic signed [W-1:0]     a_c, b_c;
    logic signed [PW-1:0]    prod;
    logic                    prod_vld;
    logic signed [ACC_W-1:0] acc, shifted_c;
    logic [W-1:0]            res_c;
    logic                    ovf_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (ce) begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state; cnt is the lane index in ISSUE and the drain count in DRAIN
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        accept_c = 1'b0;
        fin_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_n  = ISSUE;
                    cnt_n    = '0;
                end
            end
            ISSUE: begin
                if (cnt == CW'(N - 1)) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt == CW'(MUL_LAT - 1)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                fin_c = 1'b1;
                cnt_n = '0;
                if (start) begin
                    accept_c = 1'b1;
                    state_n  = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == ISSUE) || (state_n == DRAIN);
    end

    // Lane select from the latched vectors
    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                a_c = x_lat[i*W +: W];
                b_c = w_lat[i*W +: W];
            end
        end
    end

    nn_mul_pipe #(
        .W       (W),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (state == ISSUE),
        .a         (a_c),
        .b         (b_c),
        .prod      (prod),
        .out_valid (prod_vld)
    );

    assign shifted_c = acc >>> FRAC;

`ifdef NN_MAC_SAT_EN
    logic [ACC_W-W:0] hi_c;
    logic             in_range_c;

    // In range when every bit from the W-1 sign position up is identical
    always_comb begin
        hi_c       = shifted_c[ACC_W-1:W-1];
        in_range_c = (&hi_c) || (~|hi_c);
        ovf_c      = ~in_range_c;
        if (in_range_c) begin
            res_c = shifted_c[W-1:0];
        end else if (shifted_c[ACC_W-1]) begin
            res_c = {1'b1, {(W-1){1'b0}}};
        end else begin
            res_c = {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^shifted_c[ACC_W-1:W];
    assign res_c     = shifted_c[W-1:0];
    assign ovf_c     = 1'b0;
`endif

    // Operand latch, accumulator and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_lat <= '0;
            w_lat <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            total <= '0;
            sat   <= 1'b0;
        end else if (ce) begin
            busy <= busy_n;
            done <= fin_c;
            if (accept_c) begin
                x_lat <= x;
                w_lat <= w;
            end
            // Clear on accept; no tagged product is in flight at that point
            if (accept_c) begin
                acc <= '0;
            end else if (prod_vld) begin
                acc <= acc + ACC_W'(prod);
            end
            if (fin_c) begin
                total <= res_c;
                sat   <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_nn_mac_seq.sv
// Scoreboard bench for nn_mac_seq (N=8, W=17, FRAC=0, MUL_LAT=3).
module tb_nn_mac_seq;

    localparam int N = 8;
    localparam int W = 17;

    typedef struct {
        logic [W-1:0] total;
        logic         sat;
        int           cyc;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           ce;
    logic           start;
    logic [N*W-1:0] x;
    logic [N*W-1:0] w;
    logic           busy;
    logic           done;
    logic [W-1:0]   total;
    logic           sat;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc;
    logic ce_q;

    nn_mac_seq #(
        .N       (N),
        .W       (W),
        .FRAC    (0),
        .MUL_LAT (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .start (start),
        .x     (x),
        .w     (w),
        .busy  (busy),
        .done  (done),
        .total (total),
        .sat   (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc  = 0;
        ce_q = 1'b1;
    end

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        ce_q <= ce;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*W-1:0] fill(input int base, input int step);
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[i*W +: W] = W'(base + step * i);
        end
        return v;
    endfunction

    // Monitor: one new result per done seen after an enabled edge
    always @(negedge clk) begin
        if (done && ce_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("total", 32'(total), 32'(e.total));
                chk("sat", 32'(sat), 32'(e.sat));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue start for one cycle; returns the accepting edge number
    task automatic do_start(input logic [N*W-1:0] xv, input logic [N*W-1:0] wv, output int k);
        @(negedge clk);
        x     = xv;
        w     = wv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x     = '0;
        w     = '0;
        k     = cyc;
    endtask

    function automatic void push(input logic [W-1:0] t, input logic s, input int c);
        exp_t e;
        e.total = t;
        e.sat   = s;
        e.cyc   = c;
        sb.push_back(e);
    endfunction

    initial begin
        int k;
        int bc;
        logic [N*W-1:0] xs, ws;
        checks = 0;
        errors = 0;
        rst   = 1'b1;
        ce    = 1'b1;
        start = 1'b0;
        x     = '0;
        w     = '0;

        repeat (2) @(negedge clk);
        chk("rst_total", 32'(total), 32'h0);
        chk("rst_sat", 32'(sat), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Ramp: sum of i for i=0..7
        do_start(fill(1, 0), fill(0, 1), k);
        push(17'h0001C, 1'b0, k + 12);
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) bc++;
            @(negedge clk);
        end
        chk("ramp_busy_cycles", 32'(bc), 32'd11);

        // Sign: -3 * 5
        xs = '0;
        ws = '0;
        xs[W-1:0] = W'(-3);
        ws[W-1:0] = W'(5);
        do_start(xs, ws, k);
        push(17'h1FFF1, 1'b0, k + 12);
        repeat (14) @(negedge clk);

        // Overflow: 8 * 0xFFFF^2
        do_start(fill(32'h0FFFF, 0), fill(32'h0FFFF, 0), k);
`ifdef NN_MAC_SAT_EN
        push(17'h0FFFF, 1'b1, k + 12);
`else
        push(17'h00008, 1'b0, k + 12);
`endif
        repeat (14) @(negedge clk);

        // Stall in DRAIN plus an ignored start while busy
        do_start(fill(1, 0), fill(0, 1), k);
        push(17'h0001C, 1'b0, k + 17);
        repeat (3) @(negedge clk);
        x     = fill(5, 0);
        w     = fill(5, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x     = '0;
        w     = '0;
        repeat (5) @(negedge clk);
        ce = 1'b0;
        repeat (5) @(negedge clk);
        ce = 1'b1;
        repeat (12) @(negedge clk);

        // Back-to-back: second start in the DONE state cycle
        do_start(fill(1, 0), fill(0, 1), k);
        push(17'h0001C, 1'b0, k + 12);
        repeat (11) @(negedge clk);
        x     = fill(2, 0);
        w     = fill(0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x     = '0;
        w     = '0;
        push(17'h00038, 1'b0, k + 24);
        repeat (6) @(negedge clk);
        chk("b2b_total_held", 32'(total), 32'h1C);
        repeat (10) @(negedge clk);

        // Reset mid-operation aborts immediately
        do_start(fill(1, 0), fill(0, 1), k);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_total", 32'(total), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        do_start(fill(1, 0), fill(0, 1), k);
        push(17'h0001C, 1'b0, k + 12);
        repeat (16) @(negedge clk);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
